// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of pending register write-backs draining onto the
// register file write port, with two newest-wins forwarding lookups.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_reg,
  input  logic [31:0]      in_data,
  input  logic             drain_en,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  input  logic [4:0]       fwd_addr1,
  input  logic [4:0]       fwd_addr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data1,
  output logic [31:0]      fwd_data2,
  output logic [PTR_W:0]   count
);
  logic [4:0]       regs [DEPTH];
  logic [31:0]      data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, idx;
  logic             push, pop, empty;
  assign empty     = count == '0;
  assign in_ready  = count != (PTR_W+1)'(DEPTH);
  assign push      = in_valid && in_ready && in_reg != 5'd0;
  assign pop       = drain_en && !empty;
  assign RegWrite  = pop;
  assign WriteReg  = empty ? 5'd0 : regs[rd_ptr];
  assign WriteData = empty ? 32'd0 : data[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      regs[wr_ptr] <= in_reg;
      data[wr_ptr] <= in_data;
    end
  end
  // Walk oldest to newest so the newest matching entry overwrites earlier hits.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && fwd_addr1 != 5'd0 && regs[idx] == fwd_addr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data[idx];
      end
      if (valid[idx] && fwd_addr2 != 5'd0 && regs[idx] == fwd_addr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data[idx];
      end
    end
  end
endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side front end for the MIPS register file. It buffers register write-back requests from the pipeline in a small FIFO.
- It drains the FIFO one entry per cycle onto the register file's single write port (RegWrite/WriteReg/WriteData).
- It gives two read-side forwarding lookups, so values still in the queue are visible before they are committed.
- It sits between the writeback stage and the register file.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept a request this cycle.
- in_reg  in  5  destination register number.
- in_data  in  32  value to write.
- drain_en  in  1  register file write port is available this cycle.
- RegWrite  out  1  write strobe to the register file.
- WriteReg  out  5  register file write address.
- WriteData  out  32  register file write data.
- fwd_addr1  in  5  forwarding lookup address, port 1.
- fwd_addr2  in  5  forwarding lookup address, port 2.
- fwd_hit1  out  1  fwd_addr1 has a pending entry in the queue.
- fwd_hit2  out  1  fwd_addr2 has a pending entry in the queue.
- fwd_data1  out  32  newest pending value for fwd_addr1; 0 on miss.
- fwd_data2  out  32  newest pending value for fwd_addr2; 0 on miss.
- count  out  PTR_W+1  number of valid entries.

Behaviour:
- **Reset:** rst_n low asynchronously clears the read pointer, write pointer, count and all entry valid bits, whatever the queue is doing. While reset is held and after it releases:
  - RegWrite=0, WriteReg=0, WriteData=0
  - in_ready=1, count=0
  - fwd_hit1/2=0, fwd_data1/2=0
- **Ready:** in_ready = (count != DEPTH). It is registered-state only, with no combinational path from drain_en or in_valid.
- **Enqueue:** occurs on a rising edge when in_valid && in_ready.
  - If in_reg != 0, {in_reg, in_data} is stored at the write pointer, the entry is marked valid and the write pointer increments modulo DEPTH.
  - If in_reg == 0, the handshake completes but nothing is stored; count is unchanged.
- **Drain:**
  - RegWrite = drain_en && (count != 0), combinational.
  - WriteReg and WriteData show the head entry while count != 0, and are 0 when empty.
  - On a rising edge with RegWrite=1 the head is popped and the read pointer increments modulo DEPTH.
- **Latency:** a request accepted at edge N appears at the head no earlier than the cycle after edge N. With an empty queue and drain_en=1, the register file commits it at edge N+1.
- **Simultaneous push and pop:** both take effect on the same edge, so count is unchanged. A push with count==DEPTH is impossible because in_ready=0.
- **Ordering:** entries drain strictly in FIFO order, including several writes to the same register.
- **Forwarding:** combinational search over valid entries, newest to oldest.
  - The hit flag and data come from the most recently enqueued entry whose register matches the lookup address.
  - An entry being popped this cycle still hits.
  - The in-flight in_* request is not searched.
  - A lookup address of 0 never hits.
- **Pointer wrap-around:** pointers wrap modulo DEPTH; count alone distinguishes full from empty.
- **count arithmetic:** +1 on a stored push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.

Test Plan:
1. **Reset:** hold rst_n=0 mid-stream with count=3, then release → count=0, in_ready=1, RegWrite=0, WriteReg=0, WriteData=0, no forwarding hits.
2. **Single write:** push reg 5 = 32'hCAFEBABE with drain_en=1 → next cycle RegWrite=1, WriteReg=5, WriteData=32'hCAFEBABE; after that edge count=0 and RegWrite=0.
3. **Register 0 discard:** push reg 0 = 32'hFFFFFFFF → in_ready stays 1, count stays 0, RegWrite never asserts, fwd_hit1=0 for fwd_addr1=0.
4. **Fill and backpressure:** drain_en=0, push reg 1..4 with data 32'h11,22,33,44 → count=4, in_ready=0. A fifth push is not accepted. Set drain_en=1 → writes commit in order 1,2,3,4 on consecutive edges.
5. **Forwarding newest-wins:** drain_en=0, push reg 7 = 32'hA, then reg 7 = 32'hB → fwd_addr1=7 gives hit1=1 with data 32'hB, and fwd_addr2=8 gives hit2=0 with data 0. Drain one entry → data is still 32'hB. Drain the second → hit1=0.
6. **Wrap and concurrent push/pop:** DEPTH=4, stream 10 pushes with drain_en=1 every cycle → count stays 1 in steady state, pointers wrap cleanly, and all 10 values commit in order with no loss or duplication.
